bus_master_q: RTL and testbench
===============================

Name: bus_master_q

Overview:
Queued, parametrised bus master bridge between an upstream request source and the shared system bus.
- Buffers up to DEPTH requests in a FIFO and arbitrates for the bus via breq/bgrant.
- Maps the compact upstream address onto the bus address map, then issues one non-split transaction at a time.
- Returns read data, or a write completion, upstream with an error flag. Slaves that never answer raise the error flag via a timeout.

Parameters:
IN_AW, 6, upstream address width; upper SEL_W bits = slave select, remaining OFF_W = IN_AW-SEL_W bits = offset.
SEL_W, 2, slave-select field width.
SEL_LSB, 12, bus-address bit position of select field; must satisfy SEL_LSB >= OFF_W and SEL_LSB+SEL_W <= BUS_AW.
BUS_AW, 16, bus address width.
DW, 8, data width.
DEPTH, 4, request FIFO depth (power of two, >= 2).
TIMEOUT, 16, max cycles waiting for ready in XFER; 0 disables the timeout.
MAX_HOLD, 2, max back-to-back transactions per grant tenure (>= 1).
WDATA_INC, 1, constant added (mod 2^DW) to write data before issue.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  upstream request valid
in_ready  out  1  FIFO not full
in_addr  in  IN_AW  upstream address
in_wdata  in  DW  upstream write data
in_mode  in  1  1=write, 0=read
breq  out  1  bus request to arbiter
bgrant  in  1  bus grant
sl_address  out  BUS_AW  bus address
sl_wdata  out  DW  bus write data
sl_mode  out  1  bus mode, 1=write
m_valid  out  1  transaction valid
ready  in  1  slave completion
rdata  in  DW  slave read data
out_valid  out  1  one-cycle completion pulse
out_data  out  DW  read data; 0 for writes and errors
out_write  out  1  completed transaction was a write
out_err  out  1  completed by timeout

Behaviour:
- Reset: all outputs 0 except in_ready=1. FIFO flushed, state IDLE, counters 0. Reset mid-transaction drops the transaction silently; no out_valid is produced.
- Push: when in_valid && in_ready, the FIFO stores {in_mode, in_addr, in_wdata}. in_ready = !full, derived from registered count. No push occurs while full, even if a pop happens in the same cycle.
- Address map: sl_address = (sel << SEL_LSB) | offset, all other bits 0. Example: in_addr=6'b10_0101 -> 16'h2005.
- Write data: sl_wdata = in_wdata + WDATA_INC, truncated to DW.
- States:
  - IDLE: breq=0. If the FIFO is non-empty, go to REQ and set breq=1 the next cycle. Cycle numbering: push in cycle 0 -> breq high in cycle 2.
  - REQ: breq=1. On bgrant, pop the FIFO head into the address/data/mode registers, set m_valid=1 the next cycle, clear the timeout counter, increment hold_cnt, go to XFER.
  - XFER: m_valid=1 and sl_* stable. Completion occurs on the first cycle c with ready && bgrant. If bgrant drops, m_valid stays high and the block keeps waiting.
  - Timeout: the counter increments every XFER cycle. If it equals TIMEOUT-1 and there is no ready&&bgrant that cycle, the transaction completes with err. ready&&bgrant wins a same-cycle tie.
  - Completion (in cycle c+1): m_valid=0; out_valid=1 for exactly one cycle.
    - out_data = rdata captured at c, for a successful read only; otherwise 0.
    - out_write = mode; out_err as defined above.
    - rdata is sampled only on successful reads.
  - Post-completion in c+1: if the FIFO is non-empty and hold_cnt < MAX_HOLD, go to REQ with breq held at 1. Otherwise breq=0, hold_cnt=0, go to IDLE. breq stays low for at least one cycle before re-requesting.
  - m_valid is always low for at least one cycle between transactions (turnaround).
- Concurrency:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - FIFO wrap-around is by pointer modulo DEPTH.
  - Completions are returned in request order. At most one transaction is outstanding.

Decomposition:
- Package bus_master_pkg:
  - state enum {IDLE, REQ, XFER};
  - MODE_READ=1'b0, MODE_WRITE=1'b1;
  - request struct typedef {mode, addr, wdata}, parameterised via localparams in the top.
- Sub-module bus_req_fifo: synchronous FIFO with parameters DEPTH and WIDTH, ports push/pop/full/empty/count. The top instantiates it once.

Test Plan:
1. Write 8'h3F to in_addr 6'b10_0101, bgrant tied high -> breq at cycle 2; m_valid at cycle 3 with sl_address=16'h2005, sl_wdata=8'h40, sl_mode=1. With ready at cycle 4 -> out_valid at cycle 5 with out_write=1, out_data=0, out_err=0.
2. Read from in_addr 6'b01_0011 with rdata=8'hA5 while ready -> sl_address=16'h1003; out_data=8'hA5, out_write=0.
3. Push 4 requests back-to-back with bgrant low -> in_ready drops after the 4th push and the 5th is refused. With MAX_HOLD=2, granting issues 2 transactions, breq drops for 1 cycle, re-requests, and the remaining 2 follow. out_valid occurs 4 times, in order.
4. ready never asserted, TIMEOUT=16 -> completion after 16 XFER cycles with out_err=1 and out_data=0. Repeat with ready asserted on the 16th cycle -> out_err=0.
5. bgrant dropped for 3 cycles during XFER, ready high throughout -> no completion while bgrant is low; completion the cycle bgrant returns; m_valid and sl_* stable throughout.
6. rst_n low for one cycle mid-XFER with 2 queued requests -> all outputs 0, in_ready=1, no out_valid, FIFO empty, breq stays 0 afterwards.

Source files
------------

// File: rtl/bus_master_q_pkg.sv
// Shared types and constants for the queued bus master bridge.
package bus_master_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2
   } state_t;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   // Counter width able to hold values 0..v-1, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/bus_master_q_fifo.sv
// Synchronous request FIFO with registered occupancy count; show-ahead read port.
module bus_req_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // A push is refused whenever the FIFO is full, even if a pop frees a slot this cycle.
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/bus_master_q.sv
// Queued bus master: buffers upstream requests, arbitrates via breq/bgrant and
// issues one transaction at a time, returning data/completion with a timeout error.
module bus_master_q
   import bus_master_pkg::*;
#(
   parameter int unsigned IN_AW     = 6,
   parameter int unsigned SEL_W     = 2,
   parameter int unsigned SEL_LSB   = 12,
   parameter int unsigned BUS_AW    = 16,
   parameter int unsigned DW        = 8,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned TIMEOUT   = 16,
   parameter int unsigned MAX_HOLD  = 2,
   parameter int unsigned WDATA_INC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_AW-1:0]  in_addr,
   input  logic [DW-1:0]     in_wdata,
   input  logic              in_mode,
   output logic              breq,
   input  logic              bgrant,
   output logic [BUS_AW-1:0] sl_address,
   output logic [DW-1:0]     sl_wdata,
   output logic              sl_mode,
   output logic              m_valid,
   input  logic              ready,
   input  logic [DW-1:0]     rdata,
   output logic              out_valid,
   output logic [DW-1:0]     out_data,
   output logic              out_write,
   output logic              out_err
);

   localparam int unsigned OFF_W  = IN_AW - SEL_W;
   localparam int unsigned TO_W   = clog2_min1(TIMEOUT);
   localparam int unsigned HOLD_W = clog2_min1(MAX_HOLD + 1);
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic             mode;
      logic [IN_AW-1:0] addr;
      logic [DW-1:0]    wdata;
   } req_t;

   state_t              r_state;
   state_t              w_next;
   req_t                w_in_req;
   req_t                w_head;
   logic                w_full;
   logic                w_empty;
   logic [CNT_W-1:0]    w_count;
   logic                w_pop;
   logic                w_done;
   logic                w_hit;
   logic                w_timeout;
   logic [BUS_AW-1:0]   w_map_addr;
   logic [DW-1:0]       w_inc_wdata;

   logic [BUS_AW-1:0]   r_sl_addr;
   logic [DW-1:0]       r_sl_wdata;
   logic                r_sl_mode;
   logic [TO_W-1:0]     r_to_cnt;
   logic [HOLD_W-1:0]   r_hold;
   logic                r_out_valid;
   logic [DW-1:0]       r_out_data;
   logic                r_out_write;
   logic                r_out_err;

   assign w_in_req.mode  = in_mode;
   assign w_in_req.addr  = in_addr;
   assign w_in_req.wdata = in_wdata;

   bus_req_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(req_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (in_valid),
      .i_pop   (w_pop),
      .i_wdata (w_in_req),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_map_addr  = (BUS_AW'(w_head.addr[IN_AW-1:OFF_W]) << SEL_LSB)
                      | BUS_AW'(w_head.addr[OFF_W-1:0]);
   assign w_inc_wdata = w_head.wdata + DW'(WDATA_INC);
   assign w_hit       = ready && bgrant;

   always_comb begin
      w_next    = r_state;
      w_pop     = 1'b0;
      w_done    = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_count != '0) w_next = REQ;
         end
         REQ: begin
            if (bgrant && !w_empty) begin
               w_pop  = 1'b1;
               w_next = XFER;
            end
         end
         XFER: begin
            // A slave answer in the final counted cycle beats the timeout.
            if ((TIMEOUT != 0) && (r_to_cnt == TO_W'(TIMEOUT - 1)) && !w_hit)
               w_timeout = 1'b1;
            if (w_hit || w_timeout) begin
               w_done = 1'b1;
               if (!w_empty && (r_hold < HOLD_W'(MAX_HOLD)))
                  w_next = REQ;
               else
                  w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sl_addr   <= '0;
         r_sl_wdata  <= '0;
         r_sl_mode   <= MODE_READ;
         r_to_cnt    <= '0;
         r_hold      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_write <= 1'b0;
         r_out_err   <= 1'b0;
      end else begin
         r_out_valid <= w_done;
         r_out_write <= w_done && (r_sl_mode == MODE_WRITE);
         r_out_err   <= w_timeout;
         r_out_data  <= (w_done && w_hit && (r_sl_mode == MODE_READ)) ? rdata : '0;

         if (w_pop) begin
            r_sl_addr  <= w_map_addr;
            r_sl_wdata <= w_inc_wdata;
            r_sl_mode  <= w_head.mode;
            r_to_cnt   <= '0;
         end else if ((r_state == XFER) && (TIMEOUT != 0)) begin
            r_to_cnt   <= r_to_cnt + TO_W'(1);
         end

         // Tenure ends when we fall back to IDLE; the count restarts at the next grant.
         if (w_pop)
            r_hold <= r_hold + HOLD_W'(1);
         else if (w_done && (w_next == IDLE))
            r_hold <= '0;
      end
   end

   assign in_ready   = !w_full;
   assign breq       = (r_state == REQ);
   assign m_valid    = (r_state == XFER);
   assign sl_address = r_sl_addr;
   assign sl_wdata   = r_sl_wdata;
   assign sl_mode    = r_sl_mode;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_write  = r_out_write;
   assign out_err    = r_out_err;

endmodule

// File: tb/tb_bus_master_q.sv
// Scoreboard bench for bus_master_q: directed scenarios plus randomized traffic
// against an address-map/slave reference model.
module tb_bus_master_q;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [5:0]  in_addr = '0;
   logic [7:0]  in_wdata = '0;
   logic        in_mode = 1'b0;
   logic        bgrant = 1'b0;
   logic        ready = 1'b0;
   logic [7:0]  rdata = '0;
   logic        in_ready;
   logic        breq;
   logic [15:0] sl_address;
   logic [7:0]  sl_wdata;
   logic        sl_mode;
   logic        m_valid;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_write;
   logic        out_err;

   always #5 clk = ~clk;

   bus_master_q #(
      .IN_AW(6), .SEL_W(2), .SEL_LSB(12), .BUS_AW(16), .DW(8),
      .DEPTH(4), .TIMEOUT(16), .MAX_HOLD(2), .WDATA_INC(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_mode(in_mode),
      .breq(breq), .bgrant(bgrant),
      .sl_address(sl_address), .sl_wdata(sl_wdata), .sl_mode(sl_mode),
      .m_valid(m_valid), .ready(ready), .rdata(rdata),
      .out_valid(out_valid), .out_data(out_data),
      .out_write(out_write), .out_err(out_err)
   );

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        mode;
   } iss_t;

   typedef struct {
      logic        write;
      logic [7:0]  data;
      logic        err;
   } rsp_t;

   iss_t iss_q[$];
   rsp_t rsp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   auto_mode = 1'b0;
   int   xfer_cnt = 0;

   // Reference address map: select field lands at bit 12, offset stays in place.
   function automatic logic [15:0] map_addr(input logic [5:0] a);
      int s;
      int o;
      s = int'(a) / 16;
      o = int'(a) % 16;
      return 16'(s * 4096 + o);
   endfunction

   function automatic logic [7:0] slave_data(input logic [15:0] a);
      return a[7:0] ^ 8'hC3 ^ 8'(int'(a) / 4096);
   endfunction

   // Slave select 3 is an unpopulated slot that never answers.
   function automatic bit absent(input logic [15:0] a);
      return (int'(a) / 4096) == 3;
   endfunction

   function automatic rsp_t mk_rsp(input logic w, input logic [7:0] d, input logic e);
      rsp_t r;
      r.write = w;
      r.data  = d;
      r.err   = e;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic drive_slave();
      if (m_valid) xfer_cnt++;
      else         xfer_cnt = 0;
      bgrant = ($urandom_range(0, 3) != 0);
      ready  = m_valid && !absent(sl_address) && ($urandom_range(0, 2) != 0);
      if (xfer_cnt >= 8 && !absent(sl_address)) begin
         bgrant = 1'b1;
         ready  = 1'b1;
      end
      rdata = ready ? slave_data(sl_address) : 8'($urandom);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_mode) drive_slave();
   endtask

   task automatic record(input logic m, input logic [5:0] a, input logic [7:0] wd, input rsp_t r);
      iss_t e;
      e.addr  = map_addr(a);
      e.wdata = 8'(wd + 8'd1);
      e.mode  = m;
      iss_q.push_back(e);
      rsp_q.push_back(r);
   endtask

   task automatic push_req(input logic m, input logic [5:0] a, input logic [7:0] wd, input rsp_t r);
      in_valid = 1'b1;
      in_mode  = m;
      in_addr  = a;
      in_wdata = wd;
      if (in_ready) record(m, a, wd, r);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string nm, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (rsp_q.size() == 0 && !m_valid && !breq && !out_valid) break;
         tick();
      end
      chk(nm, {29'd0, rsp_q.size() == 0, m_valid, breq}, 32'b100);
   endtask

   task automatic wait_mvalid(input string nm);
      for (int i = 0; i < 20; i++) begin
         if (m_valid) break;
         tick();
      end
      chk(nm, {31'd0, m_valid}, 32'd1);
   endtask

   initial begin
      fork
         begin : monitor
            bit   prev_mv;
            iss_t cur;
            prev_mv = 1'b0;
            forever begin
               @(negedge clk);
               if (out_valid) begin
                  if (rsp_q.size() == 0) begin
                     n_cmp++;
                     n_fail++;
                     $display("FAIL spurious_out_valid: got out_valid=1 required no pending completion");
                  end else begin
                     rsp_t e;
                     e = rsp_q.pop_front();
                     chk("out_write", {31'd0, out_write}, {31'd0, e.write});
                     chk("out_data", {24'd0, out_data}, {24'd0, e.data});
                     chk("out_err", {31'd0, out_err}, {31'd0, e.err});
                  end
               end
               if (m_valid && !prev_mv) begin
                  if (iss_q.size() == 0) begin
                     n_cmp++;
                     n_fail++;
                     $display("FAIL spurious_issue: got m_valid=1 addr=%0h required no pending request", sl_address);
                  end else begin
                     cur = iss_q.pop_front();
                     chk("issue_addr", {16'd0, sl_address}, {16'd0, cur.addr});
                     chk("issue_wdata", {24'd0, sl_wdata}, {24'd0, cur.wdata});
                     chk("issue_mode", {31'd0, sl_mode}, {31'd0, cur.mode});
                  end
               end else if (m_valid) begin
                  chk("issue_stable", {7'd0, sl_address, sl_wdata, sl_mode},
                      {7'd0, cur.addr, cur.wdata, cur.mode});
               end
               prev_mv = m_valid;
            end
         end
         begin : main
            logic       m;
            logic [5:0] a;
            logic [7:0] wd;
            logic [15:0] ba;
            bit         er;
            int         k;
            int         n;

            // Reset values
            tick();
            tick();
            chk("reset_ctl", {25'd0, in_ready, breq, m_valid, out_valid, out_write, out_err, sl_mode},
                32'b1000000);
            chk("reset_data", {sl_address, sl_wdata, out_data}, 32'd0);
            rst_n = 1'b1;
            tick();

            // 1: write, grant tied high, cycle-accurate latency
            bgrant = 1'b1;
            ready  = 1'b0;
            push_req(1'b1, 6'b10_0101, 8'h3F, mk_rsp(1'b1, 8'h00, 1'b0));
            chk("t1_c1", {30'd0, breq, m_valid}, 32'b00);
            tick();
            chk("t1_c2", {30'd0, breq, m_valid}, 32'b10);
            tick();
            chk("t1_c3", {30'd0, breq, m_valid}, 32'b01);
            chk("t1_c3_bus", {sl_address, sl_wdata, 7'd0, sl_mode}, {16'h2005, 8'h40, 8'h01});
            tick();
            chk("t1_c4", {30'd0, m_valid, out_valid}, 32'b10);
            ready = 1'b1;
            tick();
            chk("t1_c5", {29'd0, out_valid, m_valid, breq}, 32'b100);
            ready = 1'b0;
            wait_drain("t1_drain", 20);

            // 2: read with slave ready
            rdata = 8'hA5;
            ready = 1'b1;
            push_req(1'b0, 6'b01_0011, 8'h00, mk_rsp(1'b0, 8'hA5, 1'b0));
            wait_mvalid("t2_mvalid");
            chk("t2_addr", {16'd0, sl_address}, {16'd0, 16'h1003});
            wait_drain("t2_drain", 20);

            // 3: fill FIFO while bus withheld, then grant-tenure limit
            ready  = 1'b0;
            bgrant = 1'b0;
            rdata  = 8'h77;
            push_req(1'b1, 6'h01, 8'h10, mk_rsp(1'b1, 8'h00, 1'b0));
            push_req(1'b0, 6'h12, 8'h00, mk_rsp(1'b0, 8'h77, 1'b0));
            push_req(1'b1, 6'h23, 8'hFF, mk_rsp(1'b1, 8'h00, 1'b0));
            push_req(1'b0, 6'h04, 8'h00, mk_rsp(1'b0, 8'h77, 1'b0));
            chk("t3_full", {31'd0, in_ready}, 32'd0);
            push_req(1'b1, 6'h05, 8'h55, mk_rsp(1'b1, 8'h00, 1'b0));
            chk("t3_still_full", {31'd0, in_ready}, 32'd0);
            bgrant = 1'b1;
            ready  = 1'b1;
            n = 0;
            for (int i = 0; i < 60 && n < 4; i++) begin
               tick();
               if (out_valid) begin
                  chk($sformatf("t3_breq_at_done%0d", n), {31'd0, breq}, (n % 2 == 0) ? 32'd1 : 32'd0);
                  n++;
               end
            end
            chk("t3_done_count", n, 4);
            wait_drain("t3_drain", 20);

            // 4a: slave never ready -> timeout after 16 XFER cycles
            ready = 1'b0;
            rdata = 8'h5C;
            push_req(1'b0, 6'h27, 8'h00, mk_rsp(1'b0, 8'h00, 1'b1));
            k = 0;
            for (int i = 0; i < 40; i++) begin
               if (out_valid) break;
               if (m_valid) k++;
               tick();
            end
            chk("t4a_xfer_cycles", k, 16);
            chk("t4a_err", {30'd0, out_valid, out_err}, 32'b11);
            wait_drain("t4a_drain", 20);

            // 4b: ready arrives on the 16th XFER cycle -> success wins the tie
            push_req(1'b0, 6'h27, 8'h00, mk_rsp(1'b0, 8'h5C, 1'b0));
            k = 0;
            for (int i = 0; i < 40; i++) begin
               if (out_valid) break;
               if (m_valid) begin
                  k++;
                  if (k == 16) ready = 1'b1;
               end
               tick();
            end
            chk("t4b_xfer_cycles", k, 16);
            chk("t4b_err", {30'd0, out_valid, out_err}, 32'b10);
            ready = 1'b0;
            wait_drain("t4b_drain", 20);

            // 5: grant removed for 3 cycles mid-transfer
            push_req(1'b1, 6'h3A, 8'h80, mk_rsp(1'b1, 8'h00, 1'b0));
            wait_mvalid("t5_mvalid");
            bgrant = 1'b0;
            ready  = 1'b1;
            for (int j = 0; j < 3; j++) begin
               tick();
               chk($sformatf("t5_hold%0d", j), {30'd0, m_valid, out_valid}, 32'b10);
            end
            bgrant = 1'b1;
            tick();
            chk("t5_done", {30'd0, m_valid, out_valid}, 32'b01);
            ready = 1'b0;
            wait_drain("t5_drain", 20);

            // 6: reset mid-transfer with two requests still queued
            push_req(1'b1, 6'h11, 8'h01, mk_rsp(1'b1, 8'h00, 1'b0));
            push_req(1'b0, 6'h22, 8'h02, mk_rsp(1'b0, 8'h00, 1'b0));
            push_req(1'b1, 6'h13, 8'h03, mk_rsp(1'b1, 8'h00, 1'b0));
            wait_mvalid("t6_mvalid");
            rst_n = 1'b0;
            tick();
            chk("t6_reset_ctl", {25'd0, in_ready, breq, m_valid, out_valid, out_write, out_err, sl_mode},
                32'b1000000);
            chk("t6_reset_data", {sl_address, sl_wdata, out_data}, 32'd0);
            rst_n = 1'b1;
            iss_q.delete();
            rsp_q.delete();
            for (int j = 0; j < 6; j++) begin
               tick();
               chk($sformatf("t6_quiet%0d", j), {28'd0, breq, m_valid, out_valid, in_ready}, 32'b0001);
            end

            // Randomized traffic against the reference model
            auto_mode = 1'b1;
            for (int i = 0; i < 3000; i++) begin
               in_valid = 1'b0;
               if ($urandom_range(0, 2) == 0) begin
                  m  = 1'($urandom);
                  a  = 6'($urandom);
                  wd = 8'($urandom);
                  in_valid = 1'b1;
                  in_mode  = m;
                  in_addr  = a;
                  in_wdata = wd;
                  if (in_ready) begin
                     ba = map_addr(a);
                     er = absent(ba);
                     record(m, a, wd, mk_rsp(m, (!m && !er) ? slave_data(ba) : 8'h00, er));
                  end
               end
               tick();
            end
            in_valid = 1'b0;
            wait_drain("rand_drain", 2000);
            auto_mode = 1'b0;
         end
         begin : watchdog
            #1000000;
            n_cmp++;
            n_fail++;
            $display("FAIL watchdog: time limit reached before the bench completed");
         end
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
